// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared constants and FSM state encoding for the register dump reader
package regfile_dump_reader_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/dump_index_counter.sv
// rtl/dump_index_counter.sv - 5-bit register index counter with load, enable and natural wrap
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset (clears count to 0)
//   load        : load load_val into the counter (takes priority over en)
//   load_val    : value to load
//   en          : advance by one; 31 wraps to 0
//   count       : current index
module dump_index_counter
    import regfile_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] load_val,
    input  logic                  en,
    output logic [REG_ADDR_W-1:0] count
);

    logic [REG_ADDR_W-1:0] count_q;
    logic [REG_ADDR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            // Width-limited add gives the 31 -> 0 wrap used by wrapping ranges.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams a range of register-file entries out over a valid/ready handshake
//
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   start           : one-cycle dump request, honoured only in IDLE
//   first_reg       : first index of the range (sampled with start)
//   last_reg        : last index of the range, inclusive (sampled with start)
//   ReadRegister    : register-file read address (always the current index)
//   ReadData        : combinational register-file data for ReadRegister
//   dump_valid      : output word available (SEND state)
//   dump_ready      : consumer accepts the word
//   dump_data       : captured register value
//   dump_index      : register index of dump_data
//   dump_last       : marks the final word of the range
//   busy            : high whenever not IDLE
//   done            : one-cycle pulse after the final handshake
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first_reg,
    input  logic [REG_ADDR_W-1:0] last_reg,
    output logic [REG_ADDR_W-1:0] ReadRegister,
    input  logic [N-1:0]          ReadData,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [N-1:0]          dump_data,
    output logic [REG_ADDR_W-1:0] dump_index,
    output logic                  dump_last,
    output logic                  busy,
    output logic                  done
);

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] stop_q, stop_d;
    logic [N-1:0]          dump_data_q, dump_data_d;
    logic [REG_ADDR_W-1:0] dump_index_q, dump_index_d;
    logic                  dump_last_q, dump_last_d;

    logic                  idx_load;
    logic                  idx_en;
    logic [REG_ADDR_W-1:0] index;

    dump_index_counter u_index (
        .clk      (clk),
        .reset    (reset),
        .load     (idx_load),
        .load_val (first_reg),
        .en       (idx_en),
        .count    (index)
    );

    always_comb begin
        state_d      = state_q;
        stop_d       = stop_q;
        dump_data_d  = dump_data_q;
        dump_index_d = dump_index_q;
        dump_last_d  = dump_last_q;
        idx_load     = 1'b0;
        idx_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_load = 1'b1;
                    stop_d   = last_reg;
                    state_d  = READ;
                end
            end
            READ: begin
                dump_data_d  = ReadData;
                dump_index_d = index;
                // Equality test handles both wrapped ranges and the full
                // 32-word dump requested as first=k, last=k-1.
                dump_last_d  = (index == stop_q);
                state_d      = SEND;
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_en  = 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            stop_q       <= '0;
            dump_data_q  <= '0;
            dump_index_q <= '0;
            dump_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stop_q       <= stop_d;
            dump_data_q  <= dump_data_d;
            dump_index_q <= dump_index_d;
            dump_last_q  <= dump_last_d;
        end
    end

    assign ReadRegister = index;
    assign dump_valid   = (state_q == SEND);
    assign dump_data    = dump_data_q;
    assign dump_index   = dump_index_q;
    assign dump_last    = dump_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   first_reg;
    logic [4:0]   last_reg;
    logic [4:0]   ReadRegister;
    logic [N-1:0] ReadData;
    logic         dump_valid;
    logic         dump_ready;
    logic [N-1:0] dump_data;
    logic [4:0]   dump_index;
    logic         dump_last;
    logic         busy;
    logic         done;

    logic [N-1:0] regs [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ReadData = regs[ReadRegister];

    regfile_dump_reader #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ReadRegister (ReadRegister),
        .ReadData     (ReadData),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_data    (dump_data),
        .dump_index   (dump_index),
        .dump_last    (dump_last),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         words;
        int         mode;
    } vec_t;

    vec_t vecs [8];

    logic [4:0]   got_idx  [$];
    logic [N-1:0] got_dat  [$];
    logic         got_last [$];
    logic [4:0]   exp_idx  [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_regs();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = '0;
    endtask

    // Reference: the range is first, first+1, ... (mod 32) up to and including last.
    task automatic build_expected(input logic [4:0] f, input logic [4:0] l);
        int idx;
        exp_idx.delete();
        idx = f;
        forever begin
            exp_idx.push_back(idx[4:0]);
            if (idx[4:0] == l) break;
            idx = (idx + 1) % 32;
        end
    endtask

    // mode 0: ready always 1; 1: random ready; 2: stall first word 5 cycles;
    // 3: random ready plus spurious start pulses while busy.
    task automatic run_dump(input string name, input logic [4:0] f, input logic [4:0] l,
                            input int mode, input int table_words);
        int           cyc;
        int           done_cnt;
        int           stall_cnt;
        bit           stalled;
        bit           finished;
        logic [N-1:0] hold_dat;
        logic [4:0]   hold_idx;
        logic         hold_last;

        build_expected(f, l);
        got_idx.delete();
        got_dat.delete();
        got_last.delete();
        done_cnt  = 0;
        stall_cnt = 0;
        stalled   = 0;
        finished  = 0;
        hold_dat  = '0;
        hold_idx  = '0;
        hold_last = 1'b0;

        first_reg  = f;
        last_reg   = l;
        start      = 1'b1;
        dump_ready = 1'b1;
        tick();
        start = 1'b0;

        for (cyc = 0; cyc < 600; cyc++) begin
            if (stalled) begin
                chk({name, " stall_hold"}, {dump_valid, hold_last, hold_idx, hold_dat},
                    {1'b1, dump_last, dump_index, dump_data});
            end
            case (mode)
                0: dump_ready = 1'b1;
                2: dump_ready = (dump_valid && stall_cnt < 5) ? 1'b0 : 1'b1;
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3) begin
                start     = 1'($urandom_range(0, 1));
                first_reg = 5'($urandom);
                last_reg  = 5'($urandom);
            end
            if (dump_valid && !dump_ready) begin
                stalled   = 1;
                stall_cnt++;
                hold_dat  = dump_data;
                hold_idx  = dump_index;
                hold_last = dump_last;
            end else begin
                stalled = 0;
            end
            if (dump_valid && dump_ready) begin
                got_idx.push_back(dump_index);
                got_dat.push_back(dump_data);
                got_last.push_back(dump_last);
            end
            if (done) begin
                done_cnt++;
                finished = 1;
                start    = 1'b0;
                break;
            end
            tick();
        end
        start      = 1'b0;
        dump_ready = 1'b1;

        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: no done within budget", name);
        end
        tick();
        chk({name, " idle_after_done"}, {busy, done, dump_valid}, 3'b000);
        chk({name, " done_count"}, done_cnt, 1);
        if (table_words > 0) chk({name, " model_words"}, exp_idx.size(), table_words);
        if (mode == 2) chk({name, " stall_cycles"}, stall_cnt, 5);
        chk({name, " word_count"}, got_idx.size(), exp_idx.size());
        for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
            chk({name, " idx"}, got_idx[k], exp_idx[k]);
            chk({name, " data"}, got_dat[k], regs[exp_idx[k]]);
            chk({name, " last"}, got_last[k], (k == exp_idx.size() - 1));
        end
    endtask

    initial begin
        logic [9:0] vvec;
        logic [9:0] dvec;

        reset      = 1'b1;
        start      = 1'b1;
        first_reg  = 5'd3;
        last_reg   = 5'd4;
        dump_ready = 1'b1;
        fill_regs();
        tick();
        tick();
        chk("reset_outputs", {dump_valid, busy, done, ReadRegister},
            {1'b0, 1'b0, 1'b0, 5'd0});
        chk("reset_capture", {dump_data, dump_index, dump_last}, '0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_reset", {busy, dump_valid}, 2'b00);

        // Latency: start in cycle 0, valid in cycles 2,4,6, done in 7.
        regs[8]  = 32'hA;
        regs[9]  = 32'hB;
        regs[10] = 32'hC;
        first_reg = 5'd8;
        last_reg  = 5'd10;
        start     = 1'b1;
        vvec = '0;
        dvec = '0;
        for (int c = 0; c < 10; c++) begin
            vvec[c] = dump_valid;
            dvec[c] = done;
            if (c == 2) chk("lat_word0", {dump_index, dump_data, dump_last}, {5'd8, 32'hA, 1'b0});
            if (c == 4) chk("lat_word1", {dump_index, dump_data, dump_last}, {5'd9, 32'hB, 1'b0});
            if (c == 6) chk("lat_word2", {dump_index, dump_data, dump_last}, {5'd10, 32'hC, 1'b1});
            tick();
            start = 1'b0;
        end
        chk("lat_valid_cycles", vvec, 10'h054);
        chk("lat_done_cycle", dvec, 10'h080);

        // Reset during SEND of the second word aborts silently.
        first_reg = 5'd8;
        last_reg  = 5'd10;
        start     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            start = 1'b0;
        end
        chk("rst_pre_send2", {dump_valid, dump_index}, {1'b1, 5'd9});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_abort", {dump_valid, busy, done}, 3'b000);
        vvec = '0;
        dvec = '0;
        for (int c = 0; c < 6; c++) begin
            vvec[c] = dump_valid;
            dvec[c] = done;
            tick();
        end
        chk("rst_no_words", vvec, '0);
        chk("rst_no_done", dvec, '0);

        vecs[0] = '{f: 5'd8,  l: 5'd10, words: 3,  mode: 0};
        vecs[1] = '{f: 5'd30, l: 5'd1,  words: 4,  mode: 0};
        vecs[2] = '{f: 5'd5,  l: 5'd5,  words: 1,  mode: 0};
        vecs[3] = '{f: 5'd8,  l: 5'd10, words: 3,  mode: 2};
        vecs[4] = '{f: 5'd2,  l: 5'd9,  words: 8,  mode: 3};
        vecs[5] = '{f: 5'd0,  l: 5'd31, words: 32, mode: 1};
        vecs[6] = '{f: 5'd7,  l: 5'd6,  words: 32, mode: 1};
        vecs[7] = '{f: 5'd31, l: 5'd0,  words: 2,  mode: 1};

        for (int v = 0; v < 8; v++) begin
            fill_regs();
            run_dump($sformatf("vec%0d", v), vecs[v].f, vecs[v].l, vecs[v].mode, vecs[v].words);
        end

        for (int r = 0; r < 6; r++) begin
            fill_regs();
            run_dump($sformatf("rnd%0d", r), 5'($urandom), 5'($urandom),
                     $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
